project_scheduler: RTL
======================

PROJECT_SCHEDULER -- requirements
Module: project_scheduler

Interface
REQ-001 Parameters SHALL be:
- NUM_PROJECTS, default 3: number of selectable projects.
- ADDRESS_CTRL, default 32'h30000300: control register.
- ADDRESS_DWELL, default 32'h30000304: auto-rotate dwell register.
- ADDRESS_STATUS, default 32'h30000308: read-only status register.
- QUIESCE_CYCLES, default 16: outputs-gated cycles before a switch, range 1..255.
- RESET_CYCLES, default 16: project reset hold after a switch, range 1..255.

REQ-002 Ports SHALL be (clock and reset first):
- wb_clk_i  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte select.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- active_project  out  8  mux select to the harness.
- project_reset  out  1  active-high reset to all projects.
- io_gate  out  1  1 = project outputs may drive pads; 0 = harness forces io_out 0, io_oeb all 1.

Function
REQ-003 CTRL write SHALL use [7:0] target, [8] auto_en, [9] go; go is write-1-to-request, not stored, and reads back 0.
REQ-004 A CTRL write with go=1 and target >= NUM_PROJECTS SHALL be ignored and set sticky status err; a later valid go SHALL clear err.
REQ-005 A valid go SHALL load a single-entry pending request; a second go before service SHALL overwrite the target (last write wins).
REQ-006 The FSM SHALL have states RUN, QUIESCE, SWITCH and RESET_HOLD.
REQ-007 RUN SHALL drive io_gate=1 and project_reset=0; a pending request SHALL cause entry to QUIESCE on the next cycle.
REQ-008 QUIESCE SHALL hold io_gate=0 for exactly QUIESCE_CYCLES cycles, then go to SWITCH.
REQ-009 SWITCH SHALL last 1 cycle: active_project <= pending target, pending cleared, project_reset=1, io_gate=0.
REQ-010 RESET_HOLD SHALL hold project_reset=1 and io_gate=0 for RESET_CYCLES cycles, then return to RUN.
REQ-011 A go while not in RUN SHALL remain pending and be serviced on the first RUN cycle.
REQ-012 A switch to the already-active project SHALL still execute the full sequence; this is the project soft-reset path.
REQ-013 Auto-rotate: in RUN with auto_en=1 and DWELL!=0, a 32-bit dwell counter SHALL increment each cycle.
REQ-014 When the dwell counter reaches DWELL-1, the block SHALL post pending = (active_project+1) mod NUM_PROJECTS, wrapping NUM_PROJECTS-1 to 0.
REQ-015 The dwell counter SHALL clear on any exit from RUN, on any DWELL write, and when auto_en=0.
REQ-016 When a manual go and an auto-rotate event fall in the same cycle, the manual target SHALL win.
REQ-017 STATUS read SHALL return [7:0] active_project, [9:8] state encoding (RUN=0, QUIESCE=1, SWITCH=2, RESET_HOLD=3), [10] busy (state!=RUN or pending), [11] err, [12] auto_en, other bits 0.
REQ-018 CTRL and DWELL SHALL be readable.
REQ-019 Writes SHALL honour wbs_sel_i per byte.
REQ-020 Any read or write to a mapped address SHALL produce a one-cycle wbs_ack_o pulse the cycle after valid (cyc&&stb), with registered wbs_dat_o in the same cycle.
REQ-021 The block SHALL not re-ack while the same request is held with ack high; unmapped addresses SHALL produce no ack.
REQ-022 STATUS writes SHALL be acked and ignored.

Reset
REQ-023 While reset_n=0:
- active_project=0, pending cleared, err=0, auto_en=0, DWELL=0.
- wbs_ack_o=0, wbs_dat_o=0, io_gate=0, project_reset=1.
REQ-024 On reset release the FSM SHALL enter RESET_HOLD, giving every project a full RESET_CYCLES reset before RUN.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence and discard any pending request.

Structure
REQ-026 The addresses, state encodings and STATUS bit positions SHALL live in a shared package, mps_pkg, also used by multi-project harness top-level integration.
REQ-027 The Wishbone register file SHALL be a sub-module, project_scheduler_regs; the FSM and counters SHALL stay in project_scheduler.

Verification
REQ-028 Reset release -> project_reset=1 and io_gate=0 for 16 cycles, then RUN with active_project=0.
REQ-029 Write CTRL=0x202 (go, target 2) -> 16 cycles io_gate=0, then active_project=2, then project_reset=1 for 17 cycles (SWITCH + RESET_HOLD), then io_gate=1.
REQ-030 Write CTRL=0x205 -> ack, active_project unchanged, STATUS[11]=1; then write CTRL=0x201 -> STATUS[11]=0.
REQ-031 DWELL=100, CTRL=0x100 from project 2 -> after 100 RUN cycles active_project sequence 0 then 1 on successive rotations.
REQ-032 Go(1) during QUIESCE of go(2), then go(0) -> project 2 serviced first, then project 0; project 1 never selected.
REQ-033 Read of an unmapped address -> no ack; STATUS read -> exactly one ack pulse with state bits valid.

Source files
------------

// File: rtl/mps_pkg.sv
// Shared definitions for the multi-project scheduler: register map defaults,
// FSM state encoding, CTRL/STATUS field positions and a byte-merge helper.
package mps_pkg;

    localparam logic [31:0] ADDR_CTRL_DEFAULT   = 32'h3000_0300;
    localparam logic [31:0] ADDR_DWELL_DEFAULT  = 32'h3000_0304;
    localparam logic [31:0] ADDR_STATUS_DEFAULT = 32'h3000_0308;

    // State encoding is visible to software through STATUS[9:8].
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_QUIESCE    = 2'd1,
        ST_SWITCH     = 2'd2,
        ST_RESET_HOLD = 2'd3
    } sched_state_e;

    // CTRL fields
    localparam int CTRL_TGT_LSB  = 0;
    localparam int CTRL_AUTO_BIT = 8;
    localparam int CTRL_GO_BIT   = 9;

    // STATUS fields
    localparam int STAT_ACT_LSB   = 0;
    localparam int STAT_STATE_LSB = 8;
    localparam int STAT_BUSY_BIT  = 10;
    localparam int STAT_ERR_BIT   = 11;
    localparam int STAT_AUTO_BIT  = 12;

    // Replace the bytes of old_val selected by sel with those of wdat.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/project_scheduler_if.sv
// Wishbone slave-side bundle between the scheduler top and its register file.
interface project_scheduler_if;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;

    modport master (output stb, cyc, we, sel, adr, dat_w, input ack, dat_r);
    modport slave  (input stb, cyc, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/project_scheduler_regs.sv
// Wishbone register file: CTRL (target/auto_en/go), DWELL, read-only STATUS.
// Produces a one-cycle go request toward the FSM and holds the sticky err bit.
module project_scheduler_regs
    import mps_pkg::*;
#(
    parameter int          NUM_PROJECTS   = 3,
    parameter logic [31:0] ADDRESS_CTRL   = ADDR_CTRL_DEFAULT,
    parameter logic [31:0] ADDRESS_DWELL  = ADDR_DWELL_DEFAULT,
    parameter logic [31:0] ADDRESS_STATUS = ADDR_STATUS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    project_scheduler_if.slave  wb,
    input  logic [7:0]          active_project,
    input  sched_state_e        state,
    input  logic                busy,
    output logic                go_req,
    output logic [7:0]          go_target,
    output logic                auto_en,
    output logic [31:0]         dwell,
    output logic                dwell_wr
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        auto_q, auto_d;
    logic        err_q, err_d;
    logic [31:0] dwell_q, dwell_d;

    logic        hit_ctrl, hit_dwell, hit_status, accept, wr;
    logic [31:0] ctrl_rd, ctrl_wr, status_rd, rdata;
    logic        go_bit, tgt_ok;

    assign hit_ctrl   = (wb.adr == ADDRESS_CTRL);
    assign hit_dwell  = (wb.adr == ADDRESS_DWELL);
    assign hit_status = (wb.adr == ADDRESS_STATUS);
    // ack_q blocks a second ack while the master still holds the same request
    assign accept     = wb.cyc && wb.stb && !ack_q && (hit_ctrl || hit_dwell || hit_status);
    assign wr         = accept && wb.we;

    assign ctrl_rd = {22'd0, 1'b0, auto_q, tgt_q};
    assign ctrl_wr = sel_merge(ctrl_rd, wb.dat_w, wb.sel);
    assign go_bit  = wb.sel[1] && wb.dat_w[CTRL_GO_BIT];
    assign tgt_ok  = ({24'd0, ctrl_wr[7:0]} < 32'(NUM_PROJECTS));

    // STATUS word assembly
    always_comb begin
        status_rd = '0;
        status_rd[STAT_ACT_LSB +: 8]   = active_project;
        status_rd[STAT_STATE_LSB +: 2] = state;
        status_rd[STAT_BUSY_BIT]       = busy;
        status_rd[STAT_ERR_BIT]        = err_q;
        status_rd[STAT_AUTO_BIT]       = auto_q;
    end

    // Read mux
    always_comb begin
        rdata = '0;
        if (hit_ctrl)        rdata = ctrl_rd;
        else if (hit_dwell)  rdata = dwell_q;
        else if (hit_status) rdata = status_rd;
    end

    // Register writes, go request and bus response next-state
    always_comb begin
        tgt_d     = tgt_q;
        auto_d    = auto_q;
        err_d     = err_q;
        dwell_d   = dwell_q;
        go_req    = 1'b0;
        dwell_wr  = 1'b0;
        go_target = ctrl_wr[CTRL_TGT_LSB +: 8];
        if (wr && hit_ctrl) begin
            if (go_bit && !tgt_ok) begin
                // out-of-range go: drop the whole write, flag it
                err_d = 1'b1;
            end else begin
                tgt_d  = ctrl_wr[CTRL_TGT_LSB +: 8];
                auto_d = ctrl_wr[CTRL_AUTO_BIT];
                if (go_bit) begin
                    err_d  = 1'b0;
                    go_req = 1'b1;
                end
            end
        end
        if (wr && hit_dwell) begin
            dwell_d  = sel_merge(dwell_q, wb.dat_w, wb.sel);
            dwell_wr = 1'b1;
        end
        ack_d = accept;
        dat_d = (accept && !wb.we) ? rdata : 32'd0;
    end

    // Register state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            tgt_q   <= '0;
            auto_q  <= 1'b0;
            err_q   <= 1'b0;
            dwell_q <= '0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            tgt_q   <= tgt_d;
            auto_q  <= auto_d;
            err_q   <= err_d;
            dwell_q <= dwell_d;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.dat_r = dat_q;
    assign auto_en  = auto_q;
    assign dwell    = dwell_q;

endmodule

// File: rtl/project_scheduler.sv
// Multi-project scheduler: gates project IO, switches the active project and
// holds a reset across the switch. Optional auto-rotation on a dwell timer.
module project_scheduler
    import mps_pkg::*;
#(
    parameter int          NUM_PROJECTS   = 3,
    parameter logic [31:0] ADDRESS_CTRL   = ADDR_CTRL_DEFAULT,
    parameter logic [31:0] ADDRESS_DWELL  = ADDR_DWELL_DEFAULT,
    parameter logic [31:0] ADDRESS_STATUS = ADDR_STATUS_DEFAULT,
    parameter int          QUIESCE_CYCLES = 16,
    parameter int          RESET_CYCLES   = 16
) (
    input  logic        wb_clk_i,
    input  logic        reset_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  active_project,
    output logic        project_reset,
    output logic        io_gate
);

    project_scheduler_if wb ();

    assign wb.stb    = wbs_stb_i;
    assign wb.cyc    = wbs_cyc_i;
    assign wb.we     = wbs_we_i;
    assign wb.sel    = wbs_sel_i;
    assign wb.adr    = wbs_adr_i;
    assign wb.dat_w  = wbs_dat_i;
    assign wbs_ack_o = wb.ack;
    assign wbs_dat_o = wb.dat_r;

    sched_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         pend_vld_q, pend_vld_d;
    logic [7:0]   pend_tgt_q, pend_tgt_d;
    logic [7:0]   sw_tgt_q, sw_tgt_d;
    logic [7:0]   active_q, active_d;
    logic [31:0]  dwell_cnt_q, dwell_cnt_d;

    logic         go_req, auto_en, dwell_wr, busy, auto_evt;
    logic [7:0]   go_target, next_proj;
    logic [31:0]  dwell;

    assign busy = (state_q != ST_RUN) || pend_vld_q;

    project_scheduler_regs #(
        .NUM_PROJECTS   (NUM_PROJECTS),
        .ADDRESS_CTRL   (ADDRESS_CTRL),
        .ADDRESS_DWELL  (ADDRESS_DWELL),
        .ADDRESS_STATUS (ADDRESS_STATUS)
    ) u_regs (
        .clk            (wb_clk_i),
        .reset_n        (reset_n),
        .wb             (wb),
        .active_project (active_q),
        .state          (state_q),
        .busy           (busy),
        .go_req         (go_req),
        .go_target      (go_target),
        .auto_en        (auto_en),
        .dwell          (dwell),
        .dwell_wr       (dwell_wr)
    );

    assign next_proj = (active_q >= 8'(NUM_PROJECTS - 1)) ? 8'd0 : active_q + 8'd1;
    // Auto-rotate never overwrites a request that is already waiting.
    assign auto_evt  = (state_q == ST_RUN) && auto_en && (dwell != 32'd0) &&
                       !pend_vld_q && (dwell_cnt_q == dwell - 32'd1);

    // Next-state: switch sequencing, pending request and dwell counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_tgt_d  = pend_tgt_q;
        sw_tgt_d    = sw_tgt_q;
        active_d    = active_q;
        dwell_cnt_d = dwell_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (pend_vld_q) begin
                    // latch the target now so a go arriving mid-sequence
                    // queues behind this switch instead of redirecting it
                    state_d    = ST_QUIESCE;
                    cnt_d      = '0;
                    sw_tgt_d   = pend_tgt_q;
                    pend_vld_d = 1'b0;
                end
            end
            ST_QUIESCE: begin
                if (cnt_q == 8'(QUIESCE_CYCLES - 1)) begin
                    state_d = ST_SWITCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SWITCH: begin
                active_d = sw_tgt_q;
                state_d  = ST_RESET_HOLD;
                cnt_d    = '0;
            end
            default: begin
                if (cnt_q == 8'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase

        // manual go is applied last so it wins over auto-rotate
        if (auto_evt) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = next_proj;
        end
        if (go_req) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = go_target;
        end

        if ((state_q != ST_RUN) || !auto_en || dwell_wr || (dwell == 32'd0) || auto_evt)
            dwell_cnt_d = '0;
        else
            dwell_cnt_d = dwell_cnt_q + 32'd1;
    end

    // State register; reset lands in RESET_HOLD so every project gets a full reset
    always_ff @(posedge wb_clk_i) begin
        if (!reset_n) begin
            state_q     <= ST_RESET_HOLD;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_tgt_q  <= '0;
            sw_tgt_q    <= '0;
            active_q    <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_tgt_q  <= pend_tgt_d;
            sw_tgt_q    <= sw_tgt_d;
            active_q    <= active_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    // reset_n forces the safe output values even before the first clock edge
    assign active_project = active_q;
    assign io_gate        = reset_n && (state_q == ST_RUN);
    assign project_reset  = !reset_n || (state_q == ST_SWITCH) || (state_q == ST_RESET_HOLD);

endmodule
